reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL have parameter NREGS, default 32: register count, power of two, at least 4; ADDR_W = log2(NREGS).
REQ-003 SHALL have parameter NREAD, default 2: number of read ports, 1..4.
REQ-004 SHALL have parameter BYPASS, default 1: 1 forwards same-cycle write data to reads, 0 disables forwarding.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port rd_addr, input, NREAD*ADDR_W: read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port rd_data, output, NREAD*DATA_W: read data, packed the same way.
REQ-009 SHALL have port rd_busy, output, NREAD: port i's register has a pending producer.
REQ-010 SHALL have port wr_en, input, 1: write strobe.
REQ-011 SHALL have port wr_addr, input, ADDR_W: write address.
REQ-012 SHALL have port wr_data, input, DATA_W: write data.
REQ-013 SHALL have port alloc_en, input, 1: request to reserve a destination register.
REQ-014 SHALL have port alloc_addr, input, ADDR_W: destination to reserve.
REQ-015 SHALL have port alloc_ready, output, 1: the reservation would be accepted this cycle.
REQ-016 SHALL have port busy_cnt, output, ADDR_W+1: number of busy registers.
REQ-017 SHALL have port alloc_err, output, 1: sticky flag; an alloc was attempted while alloc_ready was 0.

Function
REQ-018 SHALL drive reads combinationally: rd_data[i] = mem[rd_addr[i]].
REQ-019 SHALL make register 0 always read 0, never busy; writes and allocs to address 0 are no-ops and are always ready.
REQ-020 SHALL write mem[wr_addr] = wr_data on the clk edge when wr_en = 1 and wr_addr != 0.
REQ-021 SHALL, when BYPASS = 1, wr_en = 1 and wr_addr == rd_addr[i] != 0, output wr_data on rd_data[i] and drive rd_busy[i] = 0 in the same cycle.
REQ-022 SHALL keep one busy bit per register: alloc accepted -> set at the edge; wr_en -> clear at the edge.
REQ-023 SHALL set busy at the edge when alloc and write target the same address in one cycle (the new producer wins).
REQ-024 SHALL compute alloc_ready = !busy[alloc_addr] OR (wr_en AND wr_addr == alloc_addr) OR alloc_addr == 0.
REQ-025 SHALL ignore alloc_en when alloc_ready = 0, leave all state unchanged, and set alloc_err to 1 until reset.
REQ-026 SHALL clear busy on a write to a non-busy register without error; the register data updates normally.
REQ-027 SHALL change busy_cnt by +1, -1 or 0 per cycle, matching the busy-bit transitions exactly; it stays at or below NREGS-1, with no wrap.
REQ-028 SHALL give rd_busy[i] combinationally from busy[rd_addr[i]], subject to the REQ-021 override.

Reset
REQ-029 SHALL, while rst = 1 and asynchronously, clear all mem entries to 0, all busy bits, busy_cnt and alloc_err.
REQ-030 SHALL, after a mid-operation reset, ignore writes and allocs presented in the reset cycle; the first edge with rst = 0 operates normally.

Structure
REQ-031 SHALL place the DATA_W, NREGS and NREAD defaults and the ADDR_W derivation in shared package rf_pkg.
REQ-032 SHALL implement the busy bits, busy_cnt, alloc_ready and alloc_err in sub-module rf_scoreboard; reg_file_sb instantiates it next to the storage array and read muxes.

Verification
REQ-033 SHALL cover write and read: wr r5 = 32'hDEADBEEF -> next cycle rd_data[0] = DEADBEEF with rd_addr[0] = 5; wr r0 = 7 -> r0 reads 0.
REQ-034 SHALL cover bypass: same-cycle wr r3 = 9, rd r3 -> rd_data = 9 with BYPASS = 1 and the old value with BYPASS = 0.
REQ-035 SHALL cover the scoreboard: alloc r4 -> rd_busy = 1 and busy_cnt = 1; wr r4 -> rd_busy = 0 and busy_cnt = 0.
REQ-036 SHALL cover collision: r4 busy, alloc r4 with no write -> alloc_ready = 0, alloc_err = 1 and busy_cnt unchanged; alloc plus wr r4 in one cycle -> r4 still busy.
REQ-037 SHALL cover async reset: rst asserted mid-cycle with r2 = 5 and 3 busy -> outputs 0 immediately, busy_cnt = 0, alloc_err = 0.
REQ-038 SHALL cover parameters: NREGS = 8, NREAD = 3, all ports reading different registers concurrently -> correct data on each.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared defaults and address-width derivation for the scoreboarded register file.
package rf_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int NREGS_DEF  = 32;
    localparam int NREAD_DEF  = 2;

    function automatic int addr_w(input int nregs);
        return $clog2(nregs);
    endfunction

    localparam int ADDR_W_DEF = addr_w(NREGS_DEF);
endpackage

// File: rtl/reg_file_sb_if.sv
// Bundle of the register-file read/write/alloc signals, with views for the
// requester, the register file and its scoreboard.
interface reg_file_sb_if import rf_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREAD  = NREAD_DEF
);
    logic [NREAD*ADDR_W-1:0] rd_addr;
    logic [NREAD*DATA_W-1:0] rd_data;
    logic [NREAD-1:0]        rd_busy;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W-1:0]       wr_data;
    logic                    alloc_en;
    logic [ADDR_W-1:0]       alloc_addr;
    logic                    alloc_ready;
    logic [ADDR_W:0]         busy_cnt;
    logic                    alloc_err;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        input  rd_data, rd_busy, alloc_ready, busy_cnt, alloc_err
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        output rd_data, rd_busy, alloc_ready, busy_cnt, alloc_err
    );

    modport sb (
        input  rd_addr, wr_en, wr_addr, alloc_en, alloc_addr,
        output rd_busy, alloc_ready, busy_cnt, alloc_err
    );
endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking: reservation acceptance, busy count, sticky
// reservation-error flag and per-read-port busy indication.
module rf_scoreboard import rf_pkg::*; #(
    parameter int NREGS  = NREGS_DEF,
    parameter int NREAD  = NREAD_DEF,
    parameter int BYPASS = 1
) (
    input logic       clk,
    input logic       rst,
    reg_file_sb_if.sb bus
);
    localparam int ADDR_W = addr_w(NREGS);

    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_next;
    logic [ADDR_W:0]   cnt;
    logic              err;
    logic              wr_hit;
    logic              alloc_ok;
    logic              alloc_acc;
    logic              inc;
    logic              dec;
    logic [NREAD-1:0]  rd_busy_v;
    logic [ADDR_W-1:0] ra;

    assign wr_hit   = bus.wr_en && (bus.wr_addr != '0);
    assign alloc_ok = !busy[bus.alloc_addr]
                   || (bus.wr_en && (bus.wr_addr == bus.alloc_addr))
                   || (bus.alloc_addr == '0);
    assign alloc_acc = bus.alloc_en && alloc_ok && (bus.alloc_addr != '0);

    // Same-address write+alloc keeps the bit set, so it nets to no count change.
    assign inc = alloc_acc && !busy[bus.alloc_addr];
    assign dec = wr_hit && busy[bus.wr_addr]
              && !(alloc_acc && (bus.alloc_addr == bus.wr_addr));

    always_comb begin
        busy_next = busy;
        if (wr_hit) begin
            busy_next[bus.wr_addr] = 1'b0;
        end
        if (alloc_acc) begin
            busy_next[bus.alloc_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
            cnt  <= '0;
            err  <= 1'b0;
        end else begin
            busy <= busy_next;
            unique case ({inc, dec})
                2'b10:   cnt <= cnt + (ADDR_W+1)'(1);
                2'b01:   cnt <= cnt - (ADDR_W+1)'(1);
                default: cnt <= cnt;
            endcase
            if (bus.alloc_en && !alloc_ok) begin
                err <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_busy_v = '0;
        ra        = '0;
        for (int unsigned i = 0; i < NREAD; i++) begin
            ra = bus.rd_addr[i*ADDR_W +: ADDR_W];
            rd_busy_v[i] = busy[ra];
            if ((BYPASS != 0) && wr_hit && (bus.wr_addr == ra)) begin
                rd_busy_v[i] = 1'b0;
            end
        end
    end

    assign bus.rd_busy     = rd_busy_v;
    assign bus.alloc_ready = alloc_ok;
    assign bus.busy_cnt    = cnt;
    assign bus.alloc_err   = err;
endmodule

// File: rtl/reg_file_sb.sv
// Multi-read, single-write register file with optional write-to-read forwarding
// and a busy-bit scoreboard for reserved destination registers.
module reg_file_sb import rf_pkg::*; #(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int NREGS  = NREGS_DEF,
    parameter  int NREAD  = NREAD_DEF,
    parameter  int BYPASS = 1,
    localparam int ADDR_W = addr_w(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREAD*ADDR_W-1:0] rd_addr,
    output logic [NREAD*DATA_W-1:0] rd_data,
    output logic [NREAD-1:0]        rd_busy,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    alloc_en,
    input  logic [ADDR_W-1:0]       alloc_addr,
    output logic                    alloc_ready,
    output logic [ADDR_W:0]         busy_cnt,
    output logic                    alloc_err
);
    reg_file_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREAD(NREAD)) sb_bus ();

    logic [DATA_W-1:0]       mem [NREGS];
    logic [NREAD*DATA_W-1:0] rd_data_v;
    logic [ADDR_W-1:0]       ra;
    logic [DATA_W-1:0]       rd;

    assign sb_bus.rd_addr    = rd_addr;
    assign sb_bus.wr_en      = wr_en;
    assign sb_bus.wr_addr    = wr_addr;
    assign sb_bus.wr_data    = wr_data;
    assign sb_bus.alloc_en   = alloc_en;
    assign sb_bus.alloc_addr = alloc_addr;

    rf_scoreboard #(.NREGS(NREGS), .NREAD(NREAD), .BYPASS(BYPASS)) u_sb (
        .clk (clk),
        .rst (rst),
        .bus (sb_bus.sb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                mem[r] <= '0;
            end
        end else if (sb_bus.wr_en && (sb_bus.wr_addr != '0)) begin
            mem[sb_bus.wr_addr] <= sb_bus.wr_data;
        end
    end

    always_comb begin
        rd_data_v = '0;
        ra        = '0;
        rd        = '0;
        for (int unsigned i = 0; i < NREAD; i++) begin
            ra = sb_bus.rd_addr[i*ADDR_W +: ADDR_W];
            rd = (ra == '0) ? '0 : mem[ra];
            if ((BYPASS != 0) && sb_bus.wr_en && (ra != '0) && (sb_bus.wr_addr == ra)) begin
                rd = sb_bus.wr_data;
            end
            rd_data_v[i*DATA_W +: DATA_W] = rd;
        end
    end

    assign sb_bus.rd_data = rd_data_v;

    assign rd_data     = sb_bus.rd_data;
    assign rd_busy     = sb_bus.rd_busy;
    assign alloc_ready = sb_bus.alloc_ready;
    assign busy_cnt    = sb_bus.busy_cnt;
    assign alloc_err   = sb_bus.alloc_err;
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench: forwarding and non-forwarding default instances share stimulus;
// a small 8x3-port instance covers the parameterised configuration.
module tb_reg_file_sb;
    import rf_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_file_sb_if #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) bus_a ();
    reg_file_sb_if #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) bus_b ();
    reg_file_sb_if #(.DATA_W(32), .ADDR_W(3), .NREAD(3)) bus_c ();

    int n_cmp = 0;
    int n_bad = 0;

    assign bus_b.rd_addr    = bus_a.rd_addr;
    assign bus_b.wr_en      = bus_a.wr_en;
    assign bus_b.wr_addr    = bus_a.wr_addr;
    assign bus_b.wr_data    = bus_a.wr_data;
    assign bus_b.alloc_en   = bus_a.alloc_en;
    assign bus_b.alloc_addr = bus_a.alloc_addr;

    reg_file_sb #(.BYPASS(1)) dut_byp (
        .clk(clk), .rst(rst),
        .rd_addr(bus_a.rd_addr), .rd_data(bus_a.rd_data), .rd_busy(bus_a.rd_busy),
        .wr_en(bus_a.wr_en), .wr_addr(bus_a.wr_addr), .wr_data(bus_a.wr_data),
        .alloc_en(bus_a.alloc_en), .alloc_addr(bus_a.alloc_addr),
        .alloc_ready(bus_a.alloc_ready), .busy_cnt(bus_a.busy_cnt), .alloc_err(bus_a.alloc_err)
    );

    reg_file_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst),
        .rd_addr(bus_b.rd_addr), .rd_data(bus_b.rd_data), .rd_busy(bus_b.rd_busy),
        .wr_en(bus_b.wr_en), .wr_addr(bus_b.wr_addr), .wr_data(bus_b.wr_data),
        .alloc_en(bus_b.alloc_en), .alloc_addr(bus_b.alloc_addr),
        .alloc_ready(bus_b.alloc_ready), .busy_cnt(bus_b.busy_cnt), .alloc_err(bus_b.alloc_err)
    );

    reg_file_sb #(.DATA_W(32), .NREGS(8), .NREAD(3), .BYPASS(1)) dut_sm (
        .clk(clk), .rst(rst),
        .rd_addr(bus_c.rd_addr), .rd_data(bus_c.rd_data), .rd_busy(bus_c.rd_busy),
        .wr_en(bus_c.wr_en), .wr_addr(bus_c.wr_addr), .wr_data(bus_c.wr_data),
        .alloc_en(bus_c.alloc_en), .alloc_addr(bus_c.alloc_addr),
        .alloc_ready(bus_c.alloc_ready), .busy_cnt(bus_c.busy_cnt), .alloc_err(bus_c.alloc_err)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ae;
        logic [4:0]  aa;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] n0;
        logic [31:0] n1;
        logic        b0;
        logic        b1;
        logic        rdy;
        logic [5:0]  cnt;
        logic        err;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ae, input logic [4:0] aa,
                         input logic [4:0] r0, input logic [4:0] r1);
        bus_a.wr_en      = we;
        bus_a.wr_addr    = wa;
        bus_a.wr_data    = wd;
        bus_a.alloc_en   = ae;
        bus_a.alloc_addr = aa;
        bus_a.rd_addr    = {r1, r0};
    endtask

    initial begin
        // we wa wd ae aa r0 r1 | d0 d1 (fwd) | n0 n1 (no fwd) | b0 b1 rdy | cnt err (after edge)
        vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0};
        vecs[2]  = '{1'b1, 5'd0, 32'h7, 1'b0, 5'd0, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0};
        vecs[3]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0};
        vecs[4]  = '{1'b1, 5'd3, 32'h9, 1'b0, 5'd0, 5'd3, 5'd3, 32'h9, 32'h9, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0};
        vecs[5]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd3, 32'h0, 32'h9, 32'h0, 32'h9, 1'b0, 1'b0, 1'b1, 6'd1, 1'b0};
        vecs[6]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 5'd4, 5'd3, 32'h0, 32'h9, 32'h0, 32'h9, 1'b1, 1'b0, 1'b0, 6'd1, 1'b0};
        vecs[7]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd3, 32'h0, 32'h9, 32'h0, 32'h9, 1'b1, 1'b0, 1'b0, 6'd1, 1'b1};
        vecs[8]  = '{1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 5'd4, 5'd4, 32'h44, 32'h44, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 6'd1, 1'b1};
        vecs[9]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 5'd4, 5'd0, 32'h44, 32'h0, 32'h44, 32'h0, 1'b1, 1'b0, 1'b0, 6'd1, 1'b1};
        vecs[10] = '{1'b1, 5'd4, 32'h55, 1'b0, 5'd4, 5'd4, 5'd6, 32'h55, 32'h0, 32'h44, 32'h0, 1'b0, 1'b0, 1'b1, 6'd0, 1'b1};
        vecs[11] = '{1'b1, 5'd7, 32'h77, 1'b1, 5'd6, 5'd7, 5'd6, 32'h77, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 6'd1, 1'b1};
        vecs[12] = '{1'b1, 5'd6, 32'h66, 1'b1, 5'd7, 5'd6, 5'd7, 32'h66, 32'h77, 32'h0, 32'h77, 1'b0, 1'b0, 1'b1, 6'd1, 1'b1};
        vecs[13] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd6, 5'd7, 32'h66, 32'h77, 32'h66, 32'h77, 1'b0, 1'b1, 1'b1, 6'd1, 1'b1};
        vecs[14] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 5'd8, 5'd7, 32'h0, 32'h77, 32'h0, 32'h77, 1'b0, 1'b1, 1'b1, 6'd2, 1'b1};

        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
        bus_c.wr_en      = 1'b0;
        bus_c.wr_addr    = '0;
        bus_c.wr_data    = '0;
        bus_c.alloc_en   = 1'b0;
        bus_c.alloc_addr = '0;
        bus_c.rd_addr    = '0;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset cnt", 64'(bus_a.busy_cnt), 64'd0);
        check("reset err", 64'(bus_a.alloc_err), 64'd0);
        check("reset r5 data", 64'(bus_a.rd_data[31:0]), 64'd0);
        check("reset busy", 64'(bus_a.rd_busy), 64'd0);

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ae, vecs[i].aa, vecs[i].r0, vecs[i].r1);
            #1;
            check($sformatf("v%0d d0", i), 64'(bus_a.rd_data[31:0]), 64'(vecs[i].d0));
            check($sformatf("v%0d d1", i), 64'(bus_a.rd_data[63:32]), 64'(vecs[i].d1));
            check($sformatf("v%0d nofwd d0", i), 64'(bus_b.rd_data[31:0]), 64'(vecs[i].n0));
            check($sformatf("v%0d nofwd d1", i), 64'(bus_b.rd_data[63:32]), 64'(vecs[i].n1));
            check($sformatf("v%0d b0", i), 64'(bus_a.rd_busy[0]), 64'(vecs[i].b0));
            check($sformatf("v%0d b1", i), 64'(bus_a.rd_busy[1]), 64'(vecs[i].b1));
            check($sformatf("v%0d ready", i), 64'(bus_a.alloc_ready), 64'(vecs[i].rdy));
            @(posedge clk);
            #1;
            check($sformatf("v%0d cnt", i), 64'(bus_a.busy_cnt), 64'(vecs[i].cnt));
            check($sformatf("v%0d err", i), 64'(bus_a.alloc_err), 64'(vecs[i].err));
            check($sformatf("v%0d nofwd cnt", i), 64'(bus_b.busy_cnt), 64'(vecs[i].cnt));
        end

        // Mid-cycle asynchronous reset with r2 = 5 and three busy registers.
        @(negedge clk);
        drive(1'b1, 5'd2, 32'h5, 1'b1, 5'd9, 5'd2, 5'd9);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd2, 5'd9);
        #1;
        check("pre-rst r2", 64'(bus_a.rd_data[31:0]), 64'h5);
        check("pre-rst r9 busy", 64'(bus_a.rd_busy[1]), 64'd1);
        check("pre-rst cnt", 64'(bus_a.busy_cnt), 64'd3);
        #2;
        rst = 1'b1;
        drive(1'b1, 5'd11, 32'hAA, 1'b1, 5'd10, 5'd2, 5'd9);
        #1;
        check("rst r2", 64'(bus_a.rd_data[31:0]), 64'd0);
        check("rst r9 busy", 64'(bus_a.rd_busy[1]), 64'd0);
        check("rst cnt", 64'(bus_a.busy_cnt), 64'd0);
        check("rst err", 64'(bus_a.alloc_err), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd10, 5'd11, 5'd10);
        #1;
        check("rst-cycle write dropped", 64'(bus_a.rd_data[31:0]), 64'd0);
        check("rst-cycle alloc dropped", 64'(bus_a.rd_busy[1]), 64'd0);
        check("post-rst cnt", 64'(bus_a.busy_cnt), 64'd0);
        check("post-rst ready", 64'(bus_a.alloc_ready), 64'd1);
        drive(1'b1, 5'd2, 32'h12, 1'b0, 5'd0, 5'd2, 5'd0);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd2, 5'd0);
        #1;
        check("first edge write", 64'(bus_a.rd_data[31:0]), 64'h12);
        check("first edge write nofwd", 64'(bus_b.rd_data[31:0]), 64'h12);

        // Fill every non-zero register: count saturates naturally at NREGS-1.
        for (int a = 1; a < 32; a++) begin
            @(negedge clk);
            drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(a), 5'd0, 5'd0);
        end
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd31, 5'd31, 5'd1);
        #1;
        check("full cnt", 64'(bus_a.busy_cnt), 64'd31);
        check("full r31 ready", 64'(bus_a.alloc_ready), 64'd0);
        check("full busy", 64'(bus_a.rd_busy), 64'h3);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd31, 5'd0);
        #1;
        check("full r0 ready", 64'(bus_a.alloc_ready), 64'd1);
        @(posedge clk);
        #1;
        check("r0 alloc cnt", 64'(bus_a.busy_cnt), 64'd31);
        check("r0 alloc err", 64'(bus_a.alloc_err), 64'd0);
        @(negedge clk);
        drive(1'b1, 5'd31, 32'h1, 1'b1, 5'd31, 5'd31, 5'd0);
        @(posedge clk);
        #1;
        check("wr+alloc full cnt", 64'(bus_a.busy_cnt), 64'd31);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd31, 5'd0);
        #1;
        check("wr+alloc still busy", 64'(bus_a.rd_busy[0]), 64'd1);
        drive(1'b1, 5'd31, 32'h2, 1'b0, 5'd0, 5'd31, 5'd0);
        @(posedge clk);
        #1;
        check("release cnt", 64'(bus_a.busy_cnt), 64'd30);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);

        // Small configuration: 8 registers, 3 concurrent read ports.
        for (int r = 1; r < 8; r++) begin
            @(negedge clk);
            bus_c.wr_en   = 1'b1;
            bus_c.wr_addr = 3'(r);
            bus_c.wr_data = 32'h100 + 32'(r);
        end
        @(negedge clk);
        bus_c.wr_en = 1'b0;
        bus_c.rd_addr = {3'd7, 3'd5, 3'd3};
        #1;
        check("sm p0 r3", 64'(bus_c.rd_data[31:0]), 64'h103);
        check("sm p1 r5", 64'(bus_c.rd_data[63:32]), 64'h105);
        check("sm p2 r7", 64'(bus_c.rd_data[95:64]), 64'h107);
        bus_c.rd_addr = {3'd6, 3'd0, 3'd1};
        #1;
        check("sm p0 r1", 64'(bus_c.rd_data[31:0]), 64'h101);
        check("sm p1 r0", 64'(bus_c.rd_data[63:32]), 64'h0);
        check("sm p2 r6", 64'(bus_c.rd_data[95:64]), 64'h106);
        bus_c.rd_addr  = {3'd7, 3'd5, 3'd2};
        bus_c.wr_en    = 1'b1;
        bus_c.wr_addr  = 3'd7;
        bus_c.wr_data  = 32'hABC;
        bus_c.alloc_en = 1'b1;
        bus_c.alloc_addr = 3'd2;
        #1;
        check("sm p0 r2", 64'(bus_c.rd_data[31:0]), 64'h102);
        check("sm p2 fwd", 64'(bus_c.rd_data[95:64]), 64'hABC);
        @(posedge clk);
        #1;
        check("sm cnt", 64'(bus_c.busy_cnt), 64'd1);
        check("sm p0 busy", 64'(bus_c.rd_busy), 64'b001);
        @(negedge clk);
        bus_c.wr_en    = 1'b0;
        bus_c.alloc_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
